adder_tree_operand_packer: RTL and testbench



---
 rtl/adder_tree_pkg.sv | 16 +
 rtl/adder_tree_operand_packer.sv | 115 +++++++++++
 tb/tb_adder_tree_operand_packer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_tree_pkg.sv
// Shared types and default sizes for the adder tree and its operand packer.
// Sized modules take their widths from parameters and use these as defaults.
package adder_tree_pkg;

    localparam int DEFAULT_ADDER_WIDTH = 28;
    localparam int DEFAULT_LANES       = 8;

    typedef logic [DEFAULT_ADDER_WIDTH-1:0] operand_t;
    typedef operand_t [DEFAULT_LANES-1:0]   lane_vec_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

endpackage

// File: rtl/adder_tree_operand_packer.sv
// Packs a serial operand stream into LANES parallel lanes for the adder tree.
// Short frames are zero padded because every lane clears when a frame is released.
module adder_tree_operand_packer
    import adder_tree_pkg::*;
#(
    parameter int ADDER_WIDTH = DEFAULT_ADDER_WIDTH,
    parameter int LANES       = DEFAULT_LANES,
    parameter int CNT_W       = $clog2(LANES + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDER_WIDTH-1:0]       in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*ADDER_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]             out_count
);

    localparam int IDX_W = $clog2(LANES);

    pack_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             in_xfer;
    logic             out_xfer;
    logic [IDX_W-1:0] wr_idx;

    assign out_valid = (state_q == HOLD);
    assign out_count = count_q;

    // A held frame only makes room when downstream takes it, so in_ready follows out_ready.
    assign in_ready = !rst && ((state_q == FILL) || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign wr_idx   = (state_q == FILL) ? idx_q : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        case (state_q)
            FILL: begin
                if (in_xfer) begin
                    count_d = CNT_W'(idx_q) + CNT_W'(1);
                    if (in_last || (idx_q == IDX_W'(LANES - 1))) begin
                        state_d = HOLD;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_xfer) begin
                    if (in_xfer) begin
                        count_d = CNT_W'(1);
                        if (in_last) begin
                            state_d = HOLD;
                            idx_d   = '0;
                        end else begin
                            state_d = FILL;
                            idx_d   = IDX_W'(1);
                        end
                    end else begin
                        state_d = FILL;
                        idx_d   = '0;
                        count_d = '0;
                    end
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    // A write beats the release clear, so an operand accepted on a release edge lands in lane 0.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic                   lane_we;
        logic [ADDER_WIDTH-1:0] lane_q;

        assign lane_we = in_xfer && (wr_idx == IDX_W'(k));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_q <= '0;
            end else if (lane_we) begin
                lane_q <= in_data;
            end else if (out_xfer) begin
                lane_q <= '0;
            end
        end

        assign out_data[k*ADDER_WIDTH +: ADDER_WIDTH] = lane_q;
    end

endmodule

// File: tb/tb_adder_tree_operand_packer.sv
// Directed vector table plus reset and random stall sequences for the operand packer.
// Expected frames are built from hand-written operand lists and a frame-level scoreboard.
module tb_adder_tree_operand_packer;

    localparam int W  = 28;
    localparam int L  = 8;
    localparam int CW = 4;
    localparam int DW = L * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          v;
        logic [W-1:0]  d;
        logic          last;
        logic          ordy;
        logic          expRdy;
        logic          expValid;
        logic [CW-1:0] expCnt;
        logic [DW-1:0] expData;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } frame_t;

    vec_t   vecs[$];
    frame_t expFrames[$];

    adder_tree_operand_packer #(
        .ADDER_WIDTH(W),
        .LANES(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkVal(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic addVec(input logic v, input logic [W-1:0] d, input logic last, input logic ordy,
                          input logic rdy, input logic val, input logic [CW-1:0] cnt,
                          input logic [DW-1:0] data);
        vec_t x;
        x.v = v; x.d = d; x.last = last; x.ordy = ordy;
        x.expRdy = rdy; x.expValid = val; x.expCnt = cnt; x.expData = data;
        vecs.push_back(x);
    endtask

    task automatic applyStimulus(input vec_t x);
        in_valid  = x.v;
        in_data   = x.d;
        in_last   = x.last;
        out_ready = x.ordy;
        #1;
        checkVal("in_ready", DW'(in_ready), DW'(x.expRdy));
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t x);
        checkVal("out_valid", DW'(out_valid), DW'(x.expValid));
        checkVal("out_count", DW'(out_count), DW'(x.expCnt));
        checkVal("out_data", out_data, x.expData);
    endtask

    task automatic runVec(input vec_t x);
        applyStimulus(x);
        checkOutput(x);
    endtask

    initial begin
        logic [DW-1:0] acc;
        logic [DW-1:0] mData;
        int            mCnt;
        int            sent;
        int            cyc;
        int            sum;
        logic          inX;
        logic          outX;
        frame_t        f;
        vec_t          x;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

        // Full frame 1..8, then release.
        acc = '0;
        for (int k = 0; k < L; k++) begin
            acc[k*W +: W] = W'(k + 1);
            addVec(1'b1, W'(k + 1), 1'b0, 1'b1, 1'b1, (k == L - 1), CW'(k + 1), acc);
        end
        addVec(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0);

        // Short frame ended by in_last, zero padded.
        acc = '0;
        acc[0 +: W] = 28'h0FFFFFFF;
        addVec(1'b1, 28'h0FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, CW'(1), acc);
        acc[W +: W] = W'(5);
        addVec(1'b1, W'(5), 1'b0, 1'b1, 1'b1, 1'b0, CW'(2), acc);
        acc[2*W +: W] = W'(7);
        addVec(1'b1, W'(7), 1'b1, 1'b1, 1'b1, 1'b1, CW'(3), acc);

        // Back-to-back single-operand frames, each accepted on a release edge.
        for (int k = 9; k <= 11; k++) begin
            acc = '0;
            acc[0 +: W] = W'(k);
            addVec(1'b1, W'(k), 1'b1, 1'b1, 1'b1, 1'b1, CW'(1), acc);
        end
        addVec(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0);

        // Full frame under 10 cycles of backpressure with an operand waiting.
        acc = '0;
        for (int k = 0; k < L; k++) begin
            acc[k*W +: W] = W'(16 + k);
            addVec(1'b1, W'(16 + k), 1'b0, 1'b1, 1'b1, (k == L - 1), CW'(k + 1), acc);
        end
        for (int k = 0; k < 10; k++)
            addVec(1'b1, W'(100), 1'b0, 1'b0, 1'b0, 1'b1, CW'(8), acc);
        acc = '0;
        acc[0 +: W] = W'(100);
        addVec(1'b1, W'(100), 1'b0, 1'b1, 1'b1, 1'b0, CW'(1), acc);
        acc[W +: W] = W'(101);
        addVec(1'b1, W'(101), 1'b1, 1'b1, 1'b1, 1'b1, CW'(2), acc);
        addVec(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0);

        #12;
        checkVal("reset_in_ready", DW'(in_ready), DW'(0));
        checkVal("reset_out_valid", DW'(out_valid), DW'(0));
        checkVal("reset_out_count", DW'(out_count), DW'(0));
        checkVal("reset_out_data", out_data, '0);
        rst = 1'b0;
        #1;
        checkVal("post_reset_in_ready", DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            runVec(vecs[i]);
            if (i == L - 1) begin
                sum = 0;
                for (int k = 0; k < L; k++) sum += int'(out_data[k*W +: W]);
                checkVal("tree_sum", DW'(sum), DW'(36));
            end
        end

        // Reset in the middle of a frame discards the partial frame.
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            acc[k*W +: W] = W'(300 + k);
            x = '{1'b1, W'(300 + k), 1'b0, 1'b1, 1'b1, 1'b0, CW'(k + 1), acc};
            runVec(x);
        end
        in_valid = 1'b1; in_data = W'(999); in_last = 1'b0; out_ready = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        checkVal("midrst_out_data", out_data, '0);
        checkVal("midrst_out_count", DW'(out_count), DW'(0));
        checkVal("midrst_out_valid", DW'(out_valid), DW'(0));
        checkVal("midrst_in_ready", DW'(in_ready), DW'(0));
        @(posedge clk);
        #1;
        checkVal("midrst_hold_in_ready", DW'(in_ready), DW'(0));
        checkVal("midrst_hold_count", DW'(out_count), DW'(0));
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkVal("midrst_release_in_ready", DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;
        acc = '0;
        for (int k = 0; k < L; k++) begin
            acc[k*W +: W] = W'(200 + k);
            x = '{1'b1, W'(200 + k), 1'b0, 1'b1, 1'b1, (k == L - 1), CW'(k + 1), acc};
            runVec(x);
        end
        x = '{1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0};
        runVec(x);

        // Random stall soak against a frame-level scoreboard.
        mData = '0; mCnt = 0; sent = 0; cyc = 0;
        while (sent < 10000 && cyc < 80000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #3;
            checkVal("soak_out_valid", DW'(out_valid), DW'(expFrames.size() != 0));
            checkVal("soak_in_ready", DW'(in_ready), DW'((expFrames.size() == 0) || out_ready));
            inX  = in_valid && in_ready;
            outX = out_valid && out_ready;
            if (outX && expFrames.size() != 0) begin
                f = expFrames.pop_front();
                checkVal("soak_frame_data", out_data, f.d);
                checkVal("soak_frame_count", DW'(out_count), DW'(f.c));
            end
            if (inX) begin
                mData[mCnt*W +: W] = in_data;
                mCnt++;
                sent++;
                if (in_last || mCnt == L) begin
                    expFrames.push_back('{mData, CW'(mCnt)});
                    mData = '0;
                    mCnt  = 0;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && expFrames.size() != 0; c++) begin
            #3;
            if (out_valid) begin
                f = expFrames.pop_front();
                checkVal("drain_frame_data", out_data, f.d);
                checkVal("drain_frame_count", DW'(out_count), DW'(f.c));
            end
            @(posedge clk);
            #1;
        end
        checkVal("soak_operands_sent", DW'(sent), DW'(10000));
        checkVal("soak_frames_left", DW'(expFrames.size()), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
